spi_frame_rx: RTL and testbench

- System-clocked SPI slave receiver with configurable frame length and SPI mode.
- Oversamples sck/sdi/cs into the clk domain and assembles a FRAME_BYTES-byte frame.
- Presents the frame on a parallel bus with a valid/ready handshake, plus overrun and framing-error flags.
- Sits between the MCU SPI link and the downstream register/coefficient loaders.

---
 rtl/spi_frame_rx.sv | 187 ++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: oversamples sck/sdi/cs into clk and delivers FRAME_BYTES-byte frames.
// Optional status-byte shift-out on sdo is enabled by defining SPI_SDO_EN.
module spi_frame_rx #(
  parameter int unsigned FRAME_BYTES = 42,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  sck,
  input  logic                                  sdi,
  input  logic                                  cs,
  output logic [8*FRAME_BYTES-1:0]              frame_data,
  output logic                                  frame_valid,
  input  logic                                  frame_ready,
  output logic [$clog2(8*FRAME_BYTES+1)-1:0]    bit_count,
  output logic                                  overrun_err,
  output logic                                  frame_err,
  input  logic                                  clr_err
`ifdef SPI_SDO_EN
  ,
  output logic                                  sdo
`endif
);

  localparam int unsigned FRAME_BITS = 8 * FRAME_BYTES;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, sdi_s, cs_s;
  logic                   rise_c, fall_c, sample_edge_c;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d, shift_in_c;
  logic [FRAME_BITS-1:0]  data_q, data_d;
  logic                   entry_q, entry_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   ferr_q, ferr_d;

  // Synchronisers; reset to the idle bus state so no false edge appears after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q <= {SYNC_STAGES{CPOL}};
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= CPOL;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_prev_q <= sck_s;
    end
  end

  assign sck_s         = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s         = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s          = cs_sync_q[SYNC_STAGES-1];
  assign rise_c        = sck_s & ~sck_prev_q;
  assign fall_c        = ~sck_s & sck_prev_q;
  assign sample_edge_c = (CPOL == CPHA) ? rise_c : fall_c;
  assign shift_in_c    = MSB_FIRST ? {shift_q[FRAME_BITS-2:0], sdi_s}
                                   : {sdi_s, shift_q[FRAME_BITS-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      entry_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      entry_q <= entry_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: error sets are applied after clr_err so a new error wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    entry_d = 1'b0;
    valid_d = valid_q;
    ovr_d   = clr_err ? 1'b0 : ovr_q;
    ferr_d  = clr_err ? 1'b0 : ferr_q;
    if (valid_q && frame_ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sample_edge_c) begin
          shift_d = shift_in_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            state_d = DONE;
            entry_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (entry_q) begin
          if (valid_q && !frame_ready) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
        if (cs_s) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sample_edge_c) begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign bit_count   = cnt_q;
  assign overrun_err = ovr_q;
  assign frame_err   = ferr_q;

`ifdef SPI_SDO_EN
  logic       launch_edge_c;
  logic [7:0] sdo_sr_q, sdo_sr_d;
  logic       sdo_q, sdo_d;

  assign launch_edge_c = (CPOL == CPHA) ? fall_c : rise_c;

  // Status byte is snapshotted at cs fall and indexed by the bit count on each launch edge
  always_comb begin
    sdo_sr_d = sdo_sr_q;
    sdo_d    = 1'b0;
    if (!cs_s) begin
      if (state_q == IDLE) begin
        sdo_sr_d = {ovr_q, ferr_q, valid_q, 5'b0};
        sdo_d    = ovr_q;
      end else if (state_q == SHIFT) begin
        sdo_d = sdo_q;
        if (launch_edge_c) begin
          sdo_d = (cnt_q < CNT_W'(8)) ? sdo_sr_q[3'(CNT_W'(7) - cnt_q)] : 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdo_sr_q <= '0;
      sdo_q    <= 1'b0;
    end else begin
      sdo_sr_q <= sdo_sr_d;
      sdo_q    <= sdo_d;
    end
  end

  assign sdo = sdo_q;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: default 42-byte mode-0 instance plus a 2-byte CPOL=1/CPHA=1/LSB-first instance.
module tb_spi_frame_rx;

  localparam int FB0 = 336;
  localparam int H   = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic           sck0, sdi0, cs0, fr0, clr0;
  logic [FB0-1:0] fd0;
  logic           fv0, ov0, fe0;
  logic [8:0]     bc0;
  logic           sck1, sdi1, cs1, fr1, clr1;
  logic [15:0]    fd1;
  logic           fv1, ov1, fe1;
  logic [4:0]     bc1;
`ifdef SPI_SDO_EN
  logic           sdo0, sdo1;
`endif

  spi_frame_rx dut0 (
    .clk(clk), .reset_n(reset_n), .sck(sck0), .sdi(sdi0), .cs(cs0),
    .frame_data(fd0), .frame_valid(fv0), .frame_ready(fr0), .bit_count(bc0),
    .overrun_err(ov0), .frame_err(fe0), .clr_err(clr0)
`ifdef SPI_SDO_EN
    , .sdo(sdo0)
`endif
  );

  spi_frame_rx #(.FRAME_BYTES(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .sck(sck1), .sdi(sdi1), .cs(cs1),
    .frame_data(fd1), .frame_valid(fv1), .frame_ready(fr1), .bit_count(bc1),
    .overrun_err(ov1), .frame_err(fe1), .clr_err(clr1)
`ifdef SPI_SDO_EN
    , .sdo(sdo1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic           stream0 [0:399];
  logic           stream1 [0:15];
  logic [FB0-1:0] exp0_q [$];
  logic [15:0]    exp1_q [$];

  task automatic chk(input string nm, input logic [FB0-1:0] act, input logic [FB0-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the i-th received bit lands at FB-1-i (MSB first) or at i (LSB first)
  function automatic logic [FB0-1:0] model0();
    logic [FB0-1:0] f;
    for (int i = 0; i < FB0; i++) f[FB0-1-i] = stream0[i];
    return f;
  endfunction

  function automatic logic [15:0] model1();
    logic [15:0] f;
    for (int i = 0; i < 16; i++) f[i] = stream1[i];
    return f;
  endfunction

  task automatic fill_random0(input int n);
    for (int i = 0; i < n; i++) stream0[i] = 1'($urandom_range(0, 1));
  endtask

  // Mode-0 master: sdi changes with the falling edge, slave samples on rising
  task automatic send0(input int nbits, input bit rdy_at_entry, input bit chk_lat,
                       input bit chk_sdo, output logic [8:0] bc_o);
    logic       v3, v4, v5;
    logic [7:0] sbyte;
    int         extra;
    v3 = 1'b0; v4 = 1'b0; v5 = 1'b0; sbyte = '0; extra = 0;
    @(posedge clk); #2 cs0 = 1'b0;
    repeat (2*H) @(posedge clk); #2;
    for (int i = 0; i < nbits; i++) begin
      sdi0 = stream0[i];
      repeat (H) @(posedge clk); #2;
`ifdef SPI_SDO_EN
      if (i < 8) sbyte[7-i] = sdo0;
      else if (sdo0) extra++;
`endif
      sck0 = 1'b1;
      for (int n = 1; n <= H; n++) begin
        @(posedge clk); #1;
        if (i == FB0-1) begin
          if (n == 3) v3 = fv0;
          if (n == 3 && rdy_at_entry) fr0 = 1'b1;
          if (n == 4) v4 = fv0;
          if (n == 5) v5 = fv0;
        end
      end
      #1 sck0 = 1'b0;
    end
    repeat (H) @(posedge clk); #2;
    bc_o = bc0;
    cs0 = 1'b1;
    repeat (2*H) @(posedge clk); #2;
    if (chk_lat) begin
      chk("latency_not_early", FB0'(v3), FB0'(0));
      chk("latency_valid_at_4", FB0'(v4), FB0'(1));
      chk("valid_one_cycle_pulse", FB0'(v5), FB0'(0));
    end
    if (chk_sdo) begin
      chk("sdo_status_byte", FB0'(sbyte), FB0'(8'h80));
      chk("sdo_tail_zero", FB0'(extra), FB0'(0));
    end
  endtask

  // CPOL=1/CPHA=1 master: sdi changes on the leading (falling) edge, sampled on rising
  task automatic send1();
    @(posedge clk); #2 cs1 = 1'b0;
    repeat (2*H) @(posedge clk); #2;
    for (int i = 0; i < 16; i++) begin
      sck1 = 1'b0;
      sdi1 = stream1[i];
      repeat (H) @(posedge clk); #2;
      sck1 = 1'b1;
      repeat (H) @(posedge clk); #2;
    end
    cs1 = 1'b1;
    repeat (2*H) @(posedge clk); #2;
  endtask

  task automatic pulse_clr0();
    @(posedge clk); #2 clr0 = 1'b1;
    @(posedge clk); #2 clr0 = 1'b0;
    @(posedge clk); #2;
  endtask

  // Monitors: pop the expected frame on every accepted handshake
  always @(negedge clk) begin
    if (reset_n && fv0 && fr0) begin
      if (exp0_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL frame0_unexpected: got %0h, expected no frame", fd0);
      end else begin
        chk("frame0_data", fd0, exp0_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && fv1 && fr1) begin
      if (exp1_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL frame1_unexpected: got %0h, expected no frame", fd1);
      end else begin
        chk("frame1_data", FB0'(fd1), FB0'(exp1_q.pop_front()));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [FB0-1:0] a_frame;
    logic [8:0]     bc_b;
    logic [7:0]     b;
    reset_n = 1'b0;
    sck0 = 1'b0; sdi0 = 1'b0; cs0 = 1'b1; fr0 = 1'b1; clr0 = 1'b0;
    sck1 = 1'b1; sdi1 = 1'b0; cs1 = 1'b1; fr1 = 1'b1; clr1 = 1'b0;
    repeat (3) @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk); #2;

    chk("reset_frame_data", fd0, '0);
    chk("reset_frame_valid", FB0'(fv0), '0);
    chk("reset_bit_count", FB0'(bc0), '0);
    chk("reset_overrun", FB0'(ov0), '0);
    chk("reset_frame_err", FB0'(fe0), '0);
    chk("reset_dut1_valid", FB0'(fv1), '0);

    // Incrementing byte pattern 0x00..0x29, bytes sent MSB first
    for (int k = 0; k < 42; k++) begin
      b = 8'(k);
      for (int j = 0; j < 8; j++) stream0[8*k+j] = b[7-j];
    end
    exp0_q.push_back(model0());
    send0(FB0, 1'b0, 1'b1, 1'b0, bc_b);
    chk("t1_top_byte", FB0'(fd0[335:328]), FB0'(8'h00));
    chk("t1_low_byte", FB0'(fd0[7:0]), FB0'(8'h29));
    chk("t1_no_overrun", FB0'(ov0), '0);
    chk("t1_no_frame_err", FB0'(fe0), '0);

    // Back-to-back frames with consumer stalled: second frame is dropped
    fr0 = 1'b0;
    fill_random0(FB0);
    a_frame = model0();
    exp0_q.push_back(a_frame);
    send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
    fill_random0(FB0);
    send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
    chk("t2_overrun_set", FB0'(ov0), FB0'(1));
    chk("t2_frame_held", fd0, a_frame);
    chk("t2_valid_held", FB0'(fv0), FB0'(1));
    chk("t2_no_frame_err", FB0'(fe0), '0);
    fr0 = 1'b1;
    repeat (3) @(posedge clk); #2;
    chk("t2_valid_cleared", FB0'(fv0), '0);
`ifdef SPI_SDO_EN
    fill_random0(FB0);
    exp0_q.push_back(model0());
    send0(FB0, 1'b0, 1'b0, 1'b1, bc_b);
`endif
    pulse_clr0();
    chk("t2_overrun_cleared", FB0'(ov0), '0);

    // Abort after 100 bits
    fill_random0(100);
    send0(100, 1'b0, 1'b0, 1'b0, bc_b);
    chk("t3_count_before_cs", FB0'(bc_b), FB0'(100));
    chk("t3_frame_err", FB0'(fe0), FB0'(1));
    chk("t3_no_valid", FB0'(fv0), '0);
    chk("t3_count_zero", FB0'(bc0), '0);
    pulse_clr0();
    chk("t3_frame_err_cleared", FB0'(fe0), '0);
    fill_random0(FB0);
    exp0_q.push_back(model0());
    send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
    chk("t3_next_frame_no_err", FB0'(fe0), '0);

    // Extra bits after a full frame
    fill_random0(340);
    exp0_q.push_back(model0());
    send0(340, 1'b0, 1'b0, 1'b0, bc_b);
    chk("t5_count_saturated", FB0'(bc_b), FB0'(336));
    chk("t5_frame_err", FB0'(fe0), FB0'(1));
    pulse_clr0();

    // Handshake on the DONE entry cycle: old consumed, new loaded, no overrun
    fr0 = 1'b0;
    fill_random0(FB0);
    exp0_q.push_back(model0());
    send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
    fill_random0(FB0);
    exp0_q.push_back(model0());
    send0(FB0, 1'b1, 1'b0, 1'b0, bc_b);
    chk("sim_no_overrun", FB0'(ov0), '0);
    chk("sim_valid_done", FB0'(fv0), '0);

    // LSB-first CPOL=1/CPHA=1 instance: 0xA5 then 0x3C, each byte LSB first
    for (int j = 0; j < 8; j++) begin
      b = 8'hA5; stream1[j] = b[j];
      b = 8'h3C; stream1[8+j] = b[j];
    end
    exp1_q.push_back(model1());
    send1();
    chk("t4_frame_data", FB0'(fd1), FB0'(16'h3CA5));
    chk("t4_no_err", FB0'({ov1, fe1}), '0);

    // Reset mid-frame: nothing delivered, remainder reads as a short frame
    fill_random0(FB0);
    fork
      send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
      begin
        repeat (1500) @(posedge clk); #3 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    join
    chk("rst_no_valid", FB0'(fv0), '0);
    chk("rst_frame_data_zero", fd0, '0);
    chk("rst_short_frame_err", FB0'(fe0), FB0'(1));
    pulse_clr0();

    for (int r = 0; r < 2; r++) begin
      fill_random0(FB0);
      exp0_q.push_back(model0());
      send0(FB0, 1'b0, 1'b0, 1'b0, bc_b);
    end

    repeat (5) @(posedge clk); #2;
    chk("scoreboard0_drained", FB0'(exp0_q.size()), '0);
    chk("scoreboard1_drained", FB0'(exp1_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
